led_fade_ctrl: RTL and testbench
================================

# led_fade_ctrl

Sixteen-channel LED PWM controller with a shared period counter and per-channel duty ramping. Requesters write target duty values over a valid/ready command port. A serial ramp engine steps each channel's current duty toward its target once per PWM period. Each channel output is gated by its switch enable. The block sits between the switch/LED pins and any command source (debounced switch logic or a future host interface).

## Interface

- PERIOD, 64: PWM period in clk cycles; legal range ≥ 32.
- STEP, 8: maximum duty change per channel per period; legal range ≥ 1.
- DW, $clog2(PERIOD+1): duty width, so PERIOD (100 %) is representable.

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- sw  in  16  per-channel enable; channel i output forced 0 when sw[i]=0.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; transfer occurs when cmd_valid && cmd_ready at a posedge.
- cmd_ch  in  4  target channel index.
- cmd_duty  in  DW  target duty in cycles high per period.
- led  out  16  registered PWM outputs.
- busy  out  1  high while the ramp engine is sweeping.
- period_tick  out  1  one-cycle pulse, high in the cycle where cnt==0.

## Operation

Storage:
- cnt: period counter, 0..PERIOD-1.
- tgt[16], cur[16], act[16]: DW bits each.
- Two-state FSM: IDLE / RAMP.
- idx: 4-bit channel index.

Period counter:
- cnt increments every cycle.
- When cnt==PERIOD-1, cnt wraps to 0.

Wrap edge (the posedge where cnt==PERIOD-1):
- act[i] <= cur[i] for all i. act is the only register compared against cnt, so duty changes take effect only at period boundaries and outputs never glitch mid-period.
- state <= RAMP, idx <= 0.

RAMP state, one channel per cycle:
- If cur[idx] < tgt[idx]: cur[idx] += min(STEP, tgt[idx] − cur[idx]).
- If cur[idx] > tgt[idx]: cur[idx] −= min(STEP, cur[idx] − tgt[idx]).
- Otherwise cur[idx] is unchanged.
- idx increments each cycle. After idx==15 is processed, state returns to IDLE.
- Ramp arithmetic never overshoots tgt and never wraps.

Commands:
- cmd_ready = (state==IDLE).
- On accept, tgt[cmd_ch] <= min(cmd_duty, PERIOD). Out-of-range duty values are clamped, not rejected.
- A command accepted on the wrap edge is legal. The ramp engine reads the new tgt value starting in the following cycle.

Outputs:
- busy = (state==RAMP).
- led[i] <= sw[i] & (cnt < act[i]), registered.
- act==0 gives constant low; act==PERIOD gives constant high.

## Timing

- Reset values: cnt=0, state=IDLE, idx=0, all tgt/cur/act=0, led=0, busy=0, period_tick=0, cmd_ready=1.
- Reset is asynchronous: asserting rst_n low mid-ramp or mid-command aborts immediately and returns everything to reset values. No command completes across reset.
- First wrap edge occurs PERIOD cycles after reset release.
- RAMP occupies exactly 16 cycles, the cycles with cnt=0..15. cmd_ready is low for exactly those cycles every period. PERIOD ≥ 32 guarantees the ramp finishes well before the next wrap.
- Latency, command accept to first visible change on led:
  - Accept completes; the next ramp updates cur.
  - The wrap after that loads act.
  - led reflects act one cycle after cnt==0 (registered output).
- A full duty change of D needs ceil(D/STEP) ramp sweeps, plus one period for the act load.
- period_tick is registered and coincides with cnt==0.
- sw changes reach led one cycle later, independent of period phase.
- With cmd_valid high while cmd_ready is low, the requester must hold cmd_ch and cmd_duty stable. Acceptance happens on the first IDLE cycle, and exactly one write occurs.

## Test plan

All scenarios use PERIOD=64, STEP=8, sw=16'hFFFF unless stated.

- Reset: hold rst_n=0, then release → led=0, cmd_ready=1, busy=0; period_tick first pulses 64 cycles after release.
- Single write: STEP=64, write ch3 duty 16 → from the second period after accept, led[3] is high 16 of 64 cycles; with sw[3]=0, led[3] stays 0; all other channels stay 0.
- Ramp: write ch0 duty 40 → act[0] sequence over successive periods is 8, 16, 24, 32, 40, then holds. Then write ch0 duty 4 → act[0] goes 32, 24, 16, 8, 4.
- Clamp: write ch5 duty 100 → tgt[5]=64; after ramp completes, led[5] is constantly high with no low cycle.
- Handshake: raise cmd_valid on the cycle after a wrap edge → cmd_ready stays low for 16 cycles and busy is high; the transfer occurs on the first IDLE cycle; exactly one tgt write occurs.
- Reset mid-ramp: assert rst_n=0 at cnt=7 during RAMP → all outputs return to reset values immediately, and after release all channel duties read as 0.

Source files
------------

// File: rtl/led_fade_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_ctrl_if
//  Description : Valid/ready command port carrying a channel index and a
//                target duty value for the LED fade controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_fade_ctrl_if #(
  parameter int DW = 7
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_ch;
  logic [DW-1:0] cmd_duty;

  // Requester side drives the command, controller answers with ready.
  modport master (output cmd_valid, cmd_ch, cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_duty, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/led_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_ctrl
//  Description : Sixteen-channel PWM LED controller. A shared period counter
//                drives all channels; a serial ramp engine moves each channel's
//                current duty toward its target by at most STEP per period, and
//                the active duty is reloaded only at period boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module led_fade_ctrl #(
  parameter int PERIOD = 64,
  parameter int STEP   = 8,
  parameter int DW     = $clog2(PERIOD + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [15:0] sw,
  led_fade_ctrl_if.slave   cmd,
  output logic [15:0]      led,
  output logic             busy,
  output logic             period_tick
);

  localparam int NCH      = 16;
  localparam int CW       = $clog2(PERIOD);
  // The gap to the target never exceeds PERIOD, so a larger STEP behaves
  // exactly like PERIOD and this keeps the constant representable in DW bits.
  localparam int STEP_EFF = (STEP > PERIOD) ? PERIOD : STEP;

  localparam logic [CW-1:0] CNT_MAX  = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PERIOD);
  localparam logic [DW-1:0] STEP_W   = DW'(STEP_EFF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               idx_q, idx_d;
  logic [NCH-1:0][DW-1:0]   tgt_q, tgt_d;
  logic [NCH-1:0][DW-1:0]   cur_q, cur_d;
  logic [NCH-1:0][DW-1:0]   act_q, act_d;
  logic [NCH-1:0]           led_q, led_d;
  logic                     tick_q, tick_d;

  logic                     wrap;
  logic                     accept;
  logic [DW-1:0]            cmd_clamped;
  logic [DW-1:0]            cur_sel;
  logic [DW-1:0]            tgt_sel;
  logic [DW-1:0]            ramp_val;

  // One ramp step for the channel under the engine: move toward the target by
  // at most STEP, landing exactly on the target when closer than that.
  always_comb begin
    cur_sel  = cur_q[idx_q];
    tgt_sel  = tgt_q[idx_q];
    ramp_val = cur_sel;
    if (cur_sel < tgt_sel) begin
      ramp_val = ((tgt_sel - cur_sel) > STEP_W) ? (cur_sel + STEP_W) : tgt_sel;
    end else if (cur_sel > tgt_sel) begin
      ramp_val = ((cur_sel - tgt_sel) > STEP_W) ? (cur_sel - STEP_W) : tgt_sel;
    end
  end

  // Period counter, command capture, ramp sequencing and act reload.
  always_comb begin
    wrap        = (cnt_q == CNT_MAX);
    cnt_d       = wrap ? '0 : (cnt_q + CW'(1));
    tick_d      = wrap;
    state_d     = state_q;
    idx_d       = idx_q;
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    act_d       = act_q;

    accept      = cmd.cmd_valid && (state_q == ST_IDLE);
    cmd_clamped = (cmd.cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd.cmd_duty;
    if (accept) begin
      tgt_d[cmd.cmd_ch] = cmd_clamped;
    end

    if (state_q == ST_RAMP) begin
      cur_d[idx_q] = ramp_val;
      idx_d        = idx_q + 4'd1;
      if (idx_q == 4'hF) begin
        state_d = ST_IDLE;
      end
    end

    // The sweep always finishes long before the wrap, so these never collide.
    if (wrap) begin
      act_d   = cur_q;
      state_d = ST_RAMP;
      idx_d   = '0;
    end
  end

  // PWM compare per channel against the period-stable active duty.
  for (genvar i = 0; i < NCH; i++) begin : g_led
    assign led_d[i] = sw[i] & (DW'(cnt_q) < act_q[i]);
  end

  // All state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tgt_q   <= '0;
      cur_q   <= '0;
      act_q   <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      act_q   <= act_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
    end
  end

  assign led           = led_q;
  assign period_tick   = tick_q;
  assign busy          = (state_q == ST_RAMP);
  assign cmd.cmd_ready = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_fade_ctrl
//  Description : Randomized self-checking bench for led_fade_ctrl against a
//                period-level behavioural model of the duty ramp and PWM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_fade_ctrl;

  localparam int PERIOD = 64;
  localparam int STEP   = 8;
  localparam int DW     = $clog2(PERIOD + 1);
  localparam int NCH    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw;
  logic [15:0] led;
  logic        busy;
  logic        period_tick;

  led_fade_ctrl_if #(.DW(DW)) cmd_if ();

  led_fade_ctrl #(.PERIOD(PERIOD), .STEP(STEP), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .cmd         (cmd_if),
    .led         (led),
    .busy        (busy),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works in periods: at each period boundary the visible duty becomes the
  // current duty, then every channel steps toward its target in one go.
  int          m_ph;
  int          m_tgt [NCH];
  int          m_cur [NCH];
  int          m_act [NCH];
  logic [15:0] m_led;
  logic        m_tick;
  logic        m_busy;
  logic        m_swept;
  logic        m_last_acc;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_led = '0; m_tick = 0; m_busy = 0; m_swept = 0; m_last_acc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = 0; m_cur[c] = 0; m_act[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [15:0] nl;
    logic        acc;
    for (int c = 0; c < NCH; c++) nl[c] = sw[c] && (m_ph < m_act[c]);
    acc = cmd_if.cmd_valid && !m_busy;
    if (acc) m_tgt[cmd_if.cmd_ch] = imin(int'(cmd_if.cmd_duty), PERIOD);
    m_tick = (m_ph == PERIOD - 1);
    if (m_ph == PERIOD - 1) begin
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = m_cur[c];
        if (m_cur[c] < m_tgt[c])      m_cur[c] += imin(STEP, m_tgt[c] - m_cur[c]);
        else if (m_cur[c] > m_tgt[c]) m_cur[c] -= imin(STEP, m_cur[c] - m_tgt[c]);
      end
      m_swept = 1;
    end
    m_ph       = (m_ph + 1) % PERIOD;
    // Sweeping one channel per cycle occupies the first NCH cycles of a period.
    m_busy     = m_swept && (m_ph < NCH);
    m_led      = nl;
    m_last_acc = acc;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- stimulus ----------------
  typedef struct { int cyc; int ch; int duty; } dcmd_t;
  dcmd_t dq[$];
  int    cyc = 0;
  bit    rand_en = 0;
  bit    gen_en = 1;

  task automatic compare_outputs();
    check_val("led",         led,              m_led);
    check_val("busy",        busy,             m_busy);
    check_val("cmd_ready",   cmd_if.cmd_ready, !m_busy);
    check_val("period_tick", period_tick,      m_tick);
  endtask

  task automatic drive_next();
    if (cmd_if.cmd_valid && !m_last_acc) return; // hold until accepted
    cmd_if.cmd_valid = 1'b0;
    if (!gen_en) return;
    if (dq.size() > 0 && cyc >= dq[0].cyc) begin
      dcmd_t d = dq.pop_front();
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_ch    = 4'(d.ch);
      cmd_if.cmd_duty  = DW'(d.duty);
    end else if (rand_en && $urandom_range(0, 5) == 0) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_ch    = 4'($urandom_range(0, 15));
      cmd_if.cmd_duty  = DW'($urandom_range(0, 127));
    end
    if (rand_en && $urandom_range(0, 49) == 0)
      sw = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      compare_outputs();
      drive_next();
      cyc++;
    end
  endtask

  initial begin
    int waited;
    sw = 16'hFFFF;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_duty  = '0;

    // Ramp up/down on ch0, clamp on ch5, plain write on ch3.
    dq.push_back('{2, 0, 40});
    dq.push_back('{4, 5, 100});
    dq.push_back('{6, 3, 16});
    dq.push_back('{PERIOD * 7, 0, 4});
    dq.push_back('{PERIOD * 13 + 1, 9, 24});

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_led",   led,              16'h0);
    check_val("rst_busy",  busy,             1'b0);
    check_val("rst_ready", cmd_if.cmd_ready, 1'b1);
    check_val("rst_tick",  period_tick,      1'b0);
    rst_n = 1'b1;

    run_cycles(PERIOD * 14);
    rand_en = 1;
    run_cycles(PERIOD * 16);

    // Abort in the middle of a sweep and confirm the reset is immediate.
    waited = 0;
    while (!(m_busy && m_ph == 7) && waited < 4 * PERIOD) begin
      run_cycles(1);
      waited++;
    end
    check_val("find_ramp_cnt7", (m_busy && m_ph == 7), 1'b1);
    #2;
    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    #1;
    check_val("async_led",   led,              16'h0);
    check_val("async_busy",  busy,             1'b0);
    check_val("async_ready", cmd_if.cmd_ready, 1'b1);
    check_val("async_tick",  period_tick,      1'b0);
    @(negedge clk);
    @(negedge clk);
    sw = 16'hFFFF;
    rst_n = 1'b1;

    // No commands: all duties must stay at zero after the reset.
    gen_en = 0;
    run_cycles(PERIOD * 3);
    gen_en = 1;
    run_cycles(PERIOD * 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
